// File: rtl/frame_sched_pkg.sv
// Shared defaults and width helper for the servo frame step scheduler.
package frame_sched_pkg;

  localparam int unsigned FRAME_CYCLES_20MS_50MHZ = 1000000;
  localparam int unsigned DEF_N_CH                = 4;
  localparam int unsigned DEF_DIV_W               = 8;
  localparam int unsigned DEF_STEP_DEPTH          = 16;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_prescaler.sv
// Servo frame prescaler: one-cycle frame_tick every FRAME_CYCLES advancing cycles.
module frame_prescaler
  import frame_sched_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_20MS_50MHZ
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic sync,
  output logic frame_evt,
  output logic frame_tick
);

  localparam int unsigned FCNT_W = cnt_width(FRAME_CYCLES);
  localparam logic [FCNT_W-1:0] LAST = FCNT_W'(FRAME_CYCLES - 1);

  logic [FCNT_W-1:0] r_fcnt;
  logic              r_frame_tick;
  logic              w_last;

  assign w_last     = (r_fcnt == LAST);
  // Strobe for the edge that produces frame_tick, so channel pulses line up with it.
  assign frame_evt  = run & ~sync & w_last;
  assign frame_tick = r_frame_tick;

  always_ff @(posedge CLK) begin
    if (RST || sync) begin
      r_fcnt       <= '0;
      r_frame_tick <= 1'b0;
    end else if (!run) begin
      r_frame_tick <= 1'b0;
    end else if (w_last) begin
      r_fcnt       <= '0;
      r_frame_tick <= 1'b1;
    end else begin
      r_fcnt       <= r_fcnt + 1'b1;
      r_frame_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_step_scheduler.sv
// Multi-channel frame-rate step-enable generator; channel i pulses every div[i]+1 frames.
// Optional per-channel step index output when STEP_CNT_EN is defined.
module frame_step_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_20MS_50MHZ,
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned DIV_W        = DEF_DIV_W
`ifdef STEP_CNT_EN
  ,
  parameter int unsigned STEP_DEPTH   = DEF_STEP_DEPTH
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  sync,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*DIV_W-1:0] div_in,
  output logic                  frame_tick,
  output logic [N_CH-1:0]       habilitador
`ifdef STEP_CNT_EN
  ,
  output logic [N_CH*cnt_width(STEP_DEPTH)-1:0] step_idx
`endif
);

  logic w_frame_evt;

  frame_prescaler #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_prescaler (
    .CLK       (CLK),
    .RST       (RST),
    .run       (run),
    .sync      (sync),
    .frame_evt (w_frame_evt),
    .frame_tick(frame_tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic             r_hab;
    logic [DIV_W-1:0] w_div;
    logic             w_fire;

    assign w_div  = div_in[i*DIV_W +: DIV_W];
    // >= so a divisor lowered below the running count fires instead of wrapping.
    assign w_fire = w_frame_evt & ch_en[i] & (r_cnt >= w_div);
    assign habilitador[i] = r_hab;

    always_ff @(posedge CLK) begin
      if (RST || sync) begin
        r_cnt <= '0;
        r_hab <= 1'b0;
      end else if (w_frame_evt) begin
        if (!ch_en[i]) begin
          r_cnt <= '0;
          r_hab <= 1'b0;
        end else if (w_fire) begin
          r_cnt <= '0;
          r_hab <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_hab <= 1'b0;
        end
      end else begin
        r_hab <= 1'b0;
      end
    end

`ifdef STEP_CNT_EN
    localparam int unsigned STEP_W = cnt_width(STEP_DEPTH);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DEPTH - 1);

    logic [STEP_W-1:0] r_step;

    assign step_idx[i*STEP_W +: STEP_W] = r_step;

    always_ff @(posedge CLK) begin
      if (RST || sync) begin
        r_step <= '0;
      end else if (w_fire) begin
        r_step <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_frame_step_scheduler.sv
// Scoreboard bench: a frame/step reference model predicts pulse events; a monitor checks them.
module tb_frame_step_scheduler;

  localparam int FC = 10;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int SD = 4;
  localparam int SW = $clog2(SD);

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               run = 1'b0;
  logic               sync = 1'b0;
  logic [NC-1:0]      ch_en = '0;
  logic [NC*DW-1:0]   div_in = '0;
  logic               frame_tick;
  logic [NC-1:0]      habilitador;
  logic [NC*SW-1:0]   step_obs;

  typedef struct {
    int            cyc;
    logic [NC-1:0] hab;
    logic [NC*SW-1:0] step;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  // Reference model state: cycles into the current frame, frames since each channel's last pulse.
  int   m_pos = 0;
  int   m_frames[NC];
  int   m_step[NC];
  int   div_a[NC];

  frame_step_scheduler #(
    .FRAME_CYCLES(FC),
    .N_CH        (NC),
    .DIV_W       (DW)
`ifdef STEP_CNT_EN
    ,
    .STEP_DEPTH  (SD)
`endif
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .run        (run),
    .sync       (sync),
    .ch_en      (ch_en),
    .div_in     (div_in),
    .frame_tick (frame_tick),
    .habilitador(habilitador)
`ifdef STEP_CNT_EN
    ,
    .step_idx   (step_obs)
`endif
  );

`ifndef STEP_CNT_EN
  assign step_obs = '0;
`endif

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Drive one cycle of inputs, advance the model for the coming edge, then let the edge happen.
  task automatic cyc(input logic r, input logic ru, input logic sy);
    exp_t e;
    RST  = r;
    run  = ru;
    sync = sy;
    for (int i = 0; i < NC; i++) div_in[i*DW +: DW] = DW'(div_a[i]);
    if (r || sy) begin
      m_pos = 0;
      for (int i = 0; i < NC; i++) begin
        m_frames[i] = 0;
        m_step[i]   = 0;
      end
    end else if (ru) begin
      m_pos++;
      if (m_pos == FC) begin
        m_pos = 0;
        e.cyc = edge_cnt + 1;
        e.hab = '0;
        for (int i = 0; i < NC; i++) begin
          if (!ch_en[i]) begin
            m_frames[i] = 0;
          end else begin
            m_frames[i]++;
            if (m_frames[i] > div_a[i]) begin
              e.hab[i]    = 1'b1;
              m_frames[i] = 0;
              m_step[i]   = (m_step[i] + 1) % SD;
            end
          end
        end
        for (int i = 0; i < NC; i++) e.step[i*SW +: SW] = SW'(m_step[i]);
        q.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (frame_tick !== 1'b0 || habilitador !== '0 || step_obs !== '0) begin
      n_err++;
      $display("FAIL %s: got tick=%b hab=%b step=%h, want all zero", name, frame_tick,
               habilitador, step_obs);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on && (frame_tick !== 1'b0 || habilitador !== '0)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL spurious@%0d: got tick=%b hab=%b, want no event", edge_cnt, frame_tick,
                 habilitador);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != edge_cnt || frame_tick !== 1'b1 || habilitador !== e.hab
`ifdef STEP_CNT_EN
            || step_obs !== e.step
`endif
        ) begin
          n_err++;
          $display("FAIL event@%0d: got tick=%b hab=%b step=%h, want cyc=%0d tick=1 hab=%b step=%h",
                   edge_cnt, frame_tick, habilitador, step_obs, e.cyc, e.hab, e.step);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NC; i++) begin
      m_frames[i] = 0;
      m_step[i]   = 0;
      div_a[i]    = i;
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check_idle("reset_state");
    mon_on = 1'b1;

    // Divisors {0,1,2,3}: pulses every 10/20/30/40 cycles.
    ch_en = '1;
    repeat (130) cyc(1'b0, 1'b1, 1'b0);

    // Lower ch1 divisor from 5 to 2 once its count reaches 4.
    div_a[1] = 5;
    cyc(1'b0, 1'b1, 1'b1);
    repeat (40) cyc(1'b0, 1'b1, 1'b0);
    div_a[1] = 2;
    repeat (60) cyc(1'b0, 1'b1, 1'b0);

    // Run low for 7 cycles mid-frame.
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0);
    repeat (50) cyc(1'b0, 1'b1, 1'b0);

    // Sync on the edge that would have been a frame event.
    for (int k = 0; k < 2 * FC && m_pos != FC - 1; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check_idle("sync_clears");
    repeat (45) cyc(1'b0, 1'b1, 1'b0);

    // Reset mid-frame while counting.
    repeat (13) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check_idle("reset_mid_frame");
    cyc(1'b1, 1'b1, 1'b0);
    repeat (50) cyc(1'b0, 1'b1, 1'b0);

    // Step index walk with div=0, then hold with ch0 disabled.
    for (int i = 0; i < NC; i++) div_a[i] = 0;
    repeat (60) cyc(1'b0, 1'b1, 1'b0);
    ch_en[0] = 1'b0;
    repeat (30) cyc(1'b0, 1'b1, 1'b0);
    ch_en[0] = 1'b1;

    // Randomized run/sync/reset/enable/divisor traffic.
    for (int k = 0; k < 2000; k++) begin
      logic r, ru, sy;
      if ($urandom_range(36, 0) == 0) begin
        ch_en = NC'($urandom);
        for (int i = 0; i < NC; i++)
          div_a[i] = ($urandom_range(15, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(4, 0);
      end
      r  = ($urandom_range(299, 0) == 0);
      sy = ($urandom_range(149, 0) == 0) || (m_pos == FC - 1 && $urandom_range(9, 0) == 0);
      ru = ($urandom_range(5, 0) != 0);
      cyc(r, ru, sy);
    end

    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events: got %0d unseen, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_step_scheduler.md
# frame_step_scheduler

Multi-channel frame-rate step-enable generator for the arm's servo sequencer. Divides CLK into a fixed servo frame (default 20 ms at 50 MHz), then, per channel, emits a one-cycle enable pulse every (divisor+1) frames so each joint advances through its position table at its own rate. Sits between the ROM position tables and the PWM generators, and owns its own frame prescaler. Successor to the single-channel frame-count enable, adding channel count, run/sync control and safe divisor updates.

## Interface
- FRAME_CYCLES, 1000000, CLK cycles per servo frame; must be ≥ 2.
- N_CH, 4, number of independent channels.
- DIV_W, 8, divisor width per channel.
- STEP_DEPTH, 16, step-index wrap value; used only with STEP_CNT_EN.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- run  in  1  1 = counters advance; 0 = freeze everything.
- sync  in  1  synchronous restart of frame and all channel counters.
- ch_en  in  N_CH  per-channel enable.
- div_in  in  N_CH*DIV_W  channel i divisor at bits [i*DIV_W +: DIV_W]; pulse period = div+1 frames.
- frame_tick  out  1  one-cycle pulse per frame.
- habilitador  out  N_CH  one-cycle step-enable pulse per channel.
- step_idx  out  N_CH*STEP_W  per-channel step index, STEP_W = $clog2(STEP_DEPTH); present only with STEP_CNT_EN.

## Operation
- Priority per edge: RST > sync > run=0 > normal.
- RST: fcnt, all cnt[i], step_idx, frame_tick, habilitador <= 0.
- sync: same clears as RST; no pulses that cycle.
- run=0: all counters hold; frame_tick and habilitador <= 0.
- Frame counter, width $clog2(FRAME_CYCLES): if fcnt==FRAME_CYCLES-1, fcnt<=0 and frame_tick<=1 (frame event); else fcnt<=fcnt+1 and frame_tick<=0.
- Channel i, evaluated only on a frame event:
  - ch_en[i]=0: cnt[i]<=0, no pulse.
  - cnt[i] ≥ div[i]: habilitador[i]<=1, cnt[i]<=0.
  - else cnt[i]<=cnt[i]+1.
- Comparison is ≥, not ==: a divisor lowered below the current count fires on the next frame event instead of wrapping through 2^DIV_W.
- div_in is sampled live at each frame event; no latching.
- div=0: pulse on every frame event.
- Outside frame events habilitador is 0; cnt[i] holds.

## Timing
- All outputs registered; no combinational input-to-output path.
- With run=1 from the first edge after RST release, the first frame_tick occurs on the FRAME_CYCLES-th edge; period is exactly FRAME_CYCLES cycles.
- habilitador[i] is coincident with frame_tick, the same cycle.
- Channel i first pulses on frame event div[i]+1 after reset/sync or after ch_en[i] rises; subsequent pulses every div[i]+1 frame events.
- run low for k cycles stretches the current frame by exactly k cycles; no event is lost or duplicated.
- ch_en[i] falling on a frame-event edge suppresses that pulse.

## Configuration
- STEP_CNT_EN defined: per-channel step_idx increments on each habilitador[i] pulse and wraps STEP_DEPTH-1 -> 0. It is cleared by RST and sync, and held when ch_en[i]=0. This gives the ROM address directly.
- Not defined: step_idx port and logic are absent; the remaining behaviour is identical.

## Structure
- frame_sched_pkg: default constants (FRAME_CYCLES_20MS_50MHZ = 1000000, default N_CH and DIV_W) and a helper function for the counter width.
- Sub-module frame_prescaler (CLK, RST, run, sync -> frame_tick) holds fcnt. The top module instantiates it and a generate loop of channel counters.

## Test plan
- FRAME_CYCLES=10, run=1, all ch_en=1, divs {0,1,2,3} -> frame_tick every 10 cycles, first on cycle 10; ch0..ch3 pulse every 10/20/30/40 cycles, aligned with frame_tick.
- div=5 on ch1; at cnt=4 change div to 2 -> ch1 fires on the next frame event, then every 3 frames.
- run low for 7 cycles mid-frame -> that frame_tick is delayed exactly 7 cycles; pulse spacing in frames is unchanged.
- sync asserted one cycle before a pending frame event -> no pulse; next frame_tick 10 cycles after sync; all channels restart their count.
- RST asserted mid-frame with channels counting -> all outputs 0 next cycle; sequence after release matches a fresh start.
- STEP_CNT_EN, STEP_DEPTH=4, div=0 -> step_idx goes 1,2,3,0,1 on successive pulses; ch_en=0 holds the value.
